uart_cmd_ctrl: RTL and testbench

Command-frame controller sitting directly behind the UART receiver. It consumes received bytes, parses a framed write command, buffers the payload and validates a checksum. Only valid frames are committed to a register-file write port, one byte per handshake. It sequences the receive datapath output into safe register writes and reports per-frame status.

---
 rtl/uart_cmd_ctrl_pkg.sv | 9 +
 rtl/cmd_payload_buf.sv | 16 +
 rtl/uart_cmd_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg: shared FSM states, rejection codes and default frame marker
package uart_cmd_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_PAYLOAD, S_CSUM, S_COMMIT} state_e;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
endpackage

// File: rtl/cmd_payload_buf.sv
// cmd_payload_buf: payload byte store, one write and one asynchronous read port
module cmd_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  always_ff @(posedge clk_i) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses checksummed write frames from the UART and commits them to a register port
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 104166
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_VALID,
  input  logic [7:0] RX_DATA,
  output logic       WR_EN,
  output logic [7:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic       WR_READY,
  output logic       CMD_OK,
  output logic       CMD_ERR,
  output logic [1:0] ERR_CODE,
  output logic       BUSY,
  output logic       DROP
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_e         state_q, state_d;
  logic [7:0]     base_q, base_d, sum_q, sum_d, buf_rd;
  logic [LW-1:0]  len_q, len_d, idx_q, idx_d;
  logic [TW-1:0]  cnt_q, cnt_d;
  logic           ok_q, ok_d, err_q, err_d, drop_q, drop_d, buf_we, in_frame, timeout;
  logic [1:0]     code_q, code_d;
  cmd_payload_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk_i  (CLK),
    .we_i   (buf_we),
    .waddr_i(idx_q[AW-1:0]),
    .wdata_i(RX_DATA),
    .raddr_i(idx_q[AW-1:0]),
    .rdata_o(buf_rd)
  );
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    len_d = len_q;
    idx_d = idx_q;
    sum_d = sum_q;
    cnt_d = '0;
    ok_d = 1'b0;
    err_d = 1'b0;
    code_d = code_q;
    drop_d = 1'b0;
    buf_we = 1'b0;
    in_frame = state_q inside {S_ADDR, S_LEN, S_PAYLOAD, S_CSUM};
    timeout = !RX_VALID && cnt_q == TW'(TIMEOUT_CYC - 1);
    case (state_q)
      S_IDLE: if (RX_VALID && RX_DATA == SYNC_BYTE) state_d = S_ADDR;
      S_ADDR: if (RX_VALID) begin
        base_d = RX_DATA;
        sum_d = RX_DATA;
        state_d = S_LEN;
      end
      S_LEN: if (RX_VALID) begin
        if (RX_DATA == 8'd0 || RX_DATA > 8'(MAX_LEN)) begin
          err_d = 1'b1;
          code_d = ERR_LEN;
          state_d = S_IDLE;
        end else begin
          len_d = RX_DATA[LW-1:0];
          sum_d = sum_q + RX_DATA;
          idx_d = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (RX_VALID) begin
        buf_we = 1'b1;
        sum_d = sum_q + RX_DATA;
        idx_d = idx_q + 1'b1;
        if (idx_d == len_q) state_d = S_CSUM;
      end
      S_CSUM: if (RX_VALID) begin
        if (8'(sum_q + RX_DATA) == 8'h00) begin
          idx_d = '0;
          state_d = S_COMMIT;
        end else begin
          err_d = 1'b1;
          code_d = ERR_CSUM;
          state_d = S_IDLE;
        end
      end
      S_COMMIT: begin
        drop_d = RX_VALID;
        if (WR_READY) begin
          idx_d = idx_q + 1'b1;
          if (idx_d == len_q) begin
            ok_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a byte arriving on the expiry cycle wins, and expiry returns the counter to 0
    if (in_frame) begin
      cnt_d = (RX_VALID || timeout) ? '0 : cnt_q + 1'b1;
      if (timeout) begin
        err_d = 1'b1;
        code_d = ERR_TIMEOUT;
        state_d = S_IDLE;
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      base_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      ok_q <= 1'b0;
      err_q <= 1'b0;
      code_q <= ERR_NONE;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      len_q <= len_d;
      idx_q <= idx_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      ok_q <= ok_d;
      err_q <= err_d;
      code_q <= code_d;
      drop_q <= drop_d;
    end
  end
  assign WR_EN = state_q == S_COMMIT;
  assign WR_ADDR = WR_EN ? base_q + 8'(idx_q) : 8'h00;
  assign WR_DATA = WR_EN ? buf_rd : 8'h00;
  assign CMD_OK = ok_q;
  assign CMD_ERR = err_q;
  assign ERR_CODE = code_q;
  assign BUSY = state_q != S_IDLE;
  assign DROP = drop_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: randomized frame stimulus checked against a frame-level reference model
module tb_uart_cmd_ctrl;
  localparam int TO = 40;
  logic       CLK = 1'b0, RST = 1'b1, RX_VALID = 1'b0, WR_READY = 1'b1;
  logic [7:0] RX_DATA = 8'h00;
  logic       WR_EN, CMD_OK, CMD_ERR, BUSY, DROP;
  logic [7:0] WR_ADDR, WR_DATA;
  logic [1:0] ERR_CODE;
  int checks = 0, errors = 0;
  int rdy_mode = 0, gap_max = 0, cyc = 0;
  int ok_cnt, err_cnt, drop_cnt, both_cnt, en_cnt, ok_cyc;
  logic [7:0] got_a[$], got_d[$];
  int got_c[$];
  logic prev_stall = 1'b0;
  logic [7:0] prev_a, prev_d;
  logic [1:0] last_code = 2'd0;

  uart_cmd_ctrl #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_VALID(RX_VALID), .RX_DATA(RX_DATA),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .CMD_OK(CMD_OK), .CMD_ERR(CMD_ERR), .ERR_CODE(ERR_CODE), .BUSY(BUSY), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0: WR_READY = 1'b1;
      1: WR_READY = ~WR_READY;
      2: WR_READY = 1'($urandom);
      default: WR_READY = 1'b0;
    endcase
  end

  always @(negedge CLK) begin
    cyc++;
    if (prev_stall) begin
      check("stall_en", WR_EN, 1);
      check("stall_addr", WR_ADDR, prev_a);
      check("stall_data", WR_DATA, prev_d);
    end
    prev_stall = WR_EN && !WR_READY && !RST;
    prev_a = WR_ADDR;
    prev_d = WR_DATA;
    if (CMD_OK) begin ok_cnt++; ok_cyc = cyc; end
    if (CMD_ERR) err_cnt++;
    if (CMD_OK && CMD_ERR) both_cnt++;
    if (DROP) drop_cnt++;
    if (WR_EN) en_cnt++;
    if (WR_EN && WR_READY && !RST) begin
      got_a.push_back(WR_ADDR);
      got_d.push_back(WR_DATA);
      got_c.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic put(input logic [7:0] b);
    RX_VALID = 1'b1;
    RX_DATA = b;
    @(posedge CLK); #1;
    RX_VALID = 1'b0;
  endtask

  task automatic clear_mon();
    ok_cnt = 0; err_cnt = 0; drop_cnt = 0; both_cnt = 0; en_cnt = 0; ok_cyc = 0;
    got_a.delete(); got_d.delete(); got_c.delete();
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] f[$]);
    logic [7:0] s = 8'h00;
    for (int i = 1; i < f.size(); i++) s += f[i];
    return -s;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_wr_en"}, WR_EN, 0);
    check({tag, "_wr_addr"}, WR_ADDR, 0);
    check({tag, "_wr_data"}, WR_DATA, 0);
    check({tag, "_ok"}, CMD_OK, 0);
    check({tag, "_err"}, CMD_ERR, 0);
    check({tag, "_code"}, ERR_CODE, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_drop"}, DROP, 0);
  endtask

  // model: frame outcome follows from LEN range and the byte sum alone
  task automatic run_frame(input logic [7:0] f[$], input int n_drop);
    logic [7:0] s = 8'h00;
    logic [7:0] ea[$], ed[$];
    int l = int'(f[2]);
    int exp_ok = 0, exp_err = 0;
    logic [1:0] code = last_code;
    for (int i = 1; i < f.size(); i++) s += f[i];
    if (l == 0 || l > 16) begin exp_err = 1; code = 2'd1; end
    else if (s != 8'h00) begin exp_err = 1; code = 2'd2; end
    else begin
      exp_ok = 1;
      for (int i = 0; i < l; i++) begin
        ea.push_back(f[1] + 8'(i));
        ed.push_back(f[3 + i]);
      end
    end
    clear_mon();
    foreach (f[i]) begin
      idle($urandom_range(gap_max, 0));
      put(f[i]);
    end
    if (exp_ok == 0) n_drop = 0;
    repeat (n_drop) put(8'hA5);
    for (int i = 0; i < 500 && ok_cnt + err_cnt == 0; i++) idle(1);
    if (ok_cnt + err_cnt == 0) check("frame_done", 0, 1);
    idle(2);
    check("ok_cnt", ok_cnt, exp_ok);
    check("err_cnt", err_cnt, exp_err);
    check("err_code", ERR_CODE, code);
    last_code = code;
    check("drop_cnt", drop_cnt, n_drop);
    check("both", both_cnt, 0);
    check("busy_end", BUSY, 0);
    check("n_wr", got_a.size(), ea.size());
    if (exp_ok == 0) check("no_wr_en", en_cnt, 0);
    for (int i = 0; i < ea.size() && i < got_a.size(); i++) begin
      check($sformatf("wr_addr%0d", i), got_a[i], ea[i]);
      check($sformatf("wr_data%0d", i), got_d[i], ed[i]);
    end
    if (exp_ok == 1 && got_c.size() > 0) begin
      check("ok_after_last", ok_cyc - got_c[got_c.size() - 1], 1);
      if (rdy_mode == 0)
        for (int i = 1; i < got_c.size(); i++) check("wr_back2back", got_c[i] - got_c[i - 1], 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f[$];
    logic [7:0] cs;
    int l;
    idle(3);
    check_quiet("reset");
    RST = 1'b0;
    clear_mon();
    put(8'h00); put(8'h5A); idle(2);
    check("idle_ignore_busy", BUSY, 0);
    check("idle_ignore_err", err_cnt, 0);

    f = {8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33};
    cs = csum_of(f);
    f.push_back(cs);
    run_frame(f, 0);
    f[6] = cs + 8'h01;
    run_frame(f, 0);
    run_frame({8'hA5, 8'h20, 8'h00}, 0);
    run_frame({8'hA5, 8'h20, 8'h11}, 0);
    f = {8'hA5, 8'h40, 8'h10};
    for (int i = 0; i < 16; i++) f.push_back(8'($urandom));
    f.push_back(csum_of(f));
    run_frame(f, 0);

    rdy_mode = 1;
    f = {8'hA5, 8'hFE, 8'h02, 8'hAA, 8'hBB};
    f.push_back(csum_of(f));
    run_frame(f, 2);
    rdy_mode = 0;

    clear_mon();
    put(8'hA5); put(8'h05); put(8'h02); put(8'h01);
    idle(TO - 1);
    check("to_early_err", CMD_ERR, 0);
    check("to_early_busy", BUSY, 1);
    idle(1);
    check("to_err", CMD_ERR, 1);
    check("to_code", ERR_CODE, 3);
    check("to_busy", BUSY, 0);
    last_code = 2'd3;
    idle(2);
    put(8'hA5); put(8'h05); put(8'h02); put(8'h01);
    idle(TO - 1);
    clear_mon();
    put(8'h02);
    check("to_race_busy", BUSY, 1);
    put(8'hF6);
    idle(6);
    check("to_race_err", err_cnt, 0);
    check("to_race_ok", ok_cnt, 1);
    check("to_race_n", got_a.size(), 2);
    if (got_a.size() == 2) begin
      check("to_race_a1", got_a[1], 8'h06);
      check("to_race_d1", got_d[1], 8'h02);
    end

    put(8'hA5); put(8'h10); put(8'h04); put(8'h11); put(8'h22);
    RST = 1'b1; idle(1);
    check_quiet("rst_payload");
    RST = 1'b0; last_code = 2'd0;
    clear_mon(); idle(5);
    check("rst_payload_pulses", ok_cnt + err_cnt, 0);

    rdy_mode = 3;
    put(8'hA5); put(8'h30); put(8'h02); put(8'h77); put(8'h88);
    put(csum_of({8'hA5, 8'h30, 8'h02, 8'h77, 8'h88}));
    idle(2);
    check("pre_rst_wr_en", WR_EN, 1);
    RST = 1'b1; idle(1);
    check_quiet("rst_commit");
    RST = 1'b0;
    rdy_mode = 0;
    clear_mon(); idle(5);
    check("rst_commit_pulses", ok_cnt + err_cnt, 0);
    check("rst_commit_wr", got_a.size(), 0);
    f = {8'hA5, 8'h30, 8'h02, 8'h77, 8'h88};
    f.push_back(csum_of(f));
    run_frame(f, 0);

    for (int k = 0; k < 30; k++) begin
      int r = $urandom_range(9, 0);
      l = r == 0 ? 0 : r == 1 ? $urandom_range(255, 17) : $urandom_range(16, 1);
      f = {8'hA5, 8'($urandom), 8'(l)};
      if (l >= 1 && l <= 16) begin
        for (int i = 0; i < l; i++) f.push_back(8'($urandom));
        cs = csum_of(f);
        if ($urandom_range(3, 0) == 0) cs += 8'($urandom_range(255, 1));
        f.push_back(cs);
      end
      rdy_mode = $urandom_range(2, 0);
      gap_max = $urandom_range(3, 0);
      run_frame(f, $urandom_range(1, 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
